// File: rtl/conv_pkg.sv
// Shared definitions for the convolution input path: packed IFMap word
// layout and the address-width helper used by the scratchpad buffers.
package conv_pkg;

  // Packed IFMap word as delivered by the IFMap FIFO.
  localparam int IFMAP_W = 18;
  localparam int EOR_BIT = IFMAP_W - 1;

  typedef struct packed {
    logic                 eor;   // last word of the current input row
    logic [IFMAP_W-2:0]   data;
  } ifmap_word_t;

  // Default scratchpad geometry.
  localparam int SPAD_DEPTH = 16;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SPAD_ADDR_W = addr_width(SPAD_DEPTH);

endpackage

// File: rtl/ifmap_spad_mem.sv
// Scratchpad storage for one IFMap row: register array with one synchronous
// write port and one asynchronous read port.
module ifmap_spad_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the popped word at the write pointer.
  // NOTE: data entries carry no reset; validity is tracked by the pointers
  // and count in the parent, so resetting the array would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifmap_window_buffer.sv
// Circular scratchpad between the IFMap FIFO and the convolution datapath.
// Holds one input row, exposes a sliding window of filter_size words and
// advances it by stride (or drops the row) on controller request.
module ifmap_window_buffer
  import conv_pkg::*;
#(
  parameter int IN_WIDTH    = IFMAP_W,
  parameter int DEPTH       = SPAD_DEPTH,
  parameter int FILTER_SIZE = 8,
  parameter int STRIDE_SIZE = 3,
  parameter int ADDR_W      = addr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   cfg_ld,
  input  logic [STRIDE_SIZE-1:0] stride,
  input  logic [FILTER_SIZE-1:0] filter_size,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      rd_idx,
  output logic [IN_WIDTH-2:0]    rd_data,
  input  logic                   next_window,
  input  logic                   next_row,
  output logic                   av_data,
  output logic                   end_of_row,
  output logic                   cfg_err
);

  // Status comparisons mix count, filter size and stride; evaluate them wide
  // enough that fsize_r + stride never wraps.
  localparam int CMP_W = ((FILTER_SIZE > ADDR_W + 1) ? FILTER_SIZE : ADDR_W + 1) + 1;
  localparam int TAG_BIT = IN_WIDTH - 1;

  localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   ONE_CNT  = 1;
  localparam logic [ADDR_W-1:0] ONE_PTR  = 1;
  localparam logic [CMP_W-1:0]  DEPTH_W  = CMP_W'(DEPTH);

  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      win_ptr;
  logic [ADDR_W:0]        count;
  logic [ADDR_W:0]        count_next;
  logic                   eor_held;
  logic [STRIDE_SIZE-1:0] stride_r;
  logic [FILTER_SIZE-1:0] fsize_r;

  logic [STRIDE_SIZE-1:0] stride_eff;
  logic [CMP_W-1:0]       count_w;
  logic [CMP_W-1:0]       fsize_w;
  logic [CMP_W-1:0]       stride_w;
  logic [ADDR_W:0]        stride_cnt;
  logic [ADDR_W-1:0]      stride_ptr;

  logic                   push;
  logic                   adv;
  logic                   row_done;
  logic [ADDR_W-1:0]      rd_addr;
  logic [IN_WIDTH-2:0]    mem_rdata;

  // A programmed stride of zero steps one word.
  assign stride_eff = (stride_r == '0) ? STRIDE_SIZE'(1) : stride_r;

  assign count_w    = CMP_W'(count);
  assign fsize_w    = CMP_W'(fsize_r);
  assign stride_w   = CMP_W'(stride_eff);
  assign stride_cnt = stride_w[ADDR_W:0];
  assign stride_ptr = stride_w[ADDR_W-1:0];

  // Status towards the FIFO and the datapath controller.
  assign cfg_err    = (fsize_w == '0) || (fsize_w > DEPTH_W);
  assign av_data    = !cfg_err && (count_w >= fsize_w);
  assign end_of_row = av_data && eor_held && (count_w < fsize_w + stride_w);

  // Stop popping once full or once this row's tagged word is resident, so a
  // second row never lands behind the current one.
  assign in_ready = (count < FULL_CNT) && !eor_held;

  assign push     = in_valid && in_ready;
  assign adv      = next_window && av_data && !end_of_row;
  assign row_done = next_row && eor_held;

  // Occupancy after a same-cycle write and window advance.
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    if (push) begin
      count_next = count_next + ONE_CNT;
    end
    if (adv) begin
      count_next = count_next - stride_cnt;
    end
  end

  // Pointer, occupancy, row-tag and configuration registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      win_ptr  <= '0;
      count    <= '0;
      eor_held <= 1'b0;
      stride_r <= '0;
      fsize_r  <= '0;
    end else begin
      if (cfg_ld) begin
        stride_r <= stride;
        fsize_r  <= filter_size;
      end
      if (clear) begin
        wr_ptr   <= '0;
        win_ptr  <= '0;
        count    <= '0;
        eor_held <= 1'b0;
      end else if (row_done) begin
        // No write can coincide: in_ready is low while eor_held is set.
        win_ptr  <= wr_ptr;
        count    <= '0;
        eor_held <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ONE_PTR;
          if (in_data[TAG_BIT]) begin
            eor_held <= 1'b1;
          end
        end
        if (adv) begin
          win_ptr <= win_ptr + stride_ptr;
        end
        count <= count_next;
      end
    end
  end

  // Window-relative read; the address wraps naturally modulo DEPTH.
  assign rd_addr = win_ptr + rd_idx;

  ifmap_spad_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (IN_WIDTH - 1),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !clear),
    .waddr (wr_ptr),
    .wdata (in_data[IN_WIDTH-2:0]),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Offsets beyond the resident words read as zero.
  assign rd_data = ({1'b0, rd_idx} >= count) ? '0 : mem_rdata;

endmodule
